// File: rtl/ofifo_pkg.sv
// rtl/ofifo_pkg.sv - shared defaults and width helpers for the output FIFO
package ofifo_pkg;

  localparam int DEF_COL       = 8;
  localparam int DEF_PSUM_BW   = 16;
  localparam int DEF_DEPTH     = 64;
  localparam int DEF_AF_MARGIN = 4;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // One extra bit so a count can represent a completely full lane.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ofifo_lane.sv
// rtl/ofifo_lane.sv - single-lane circular buffer with count/empty/full
module ofifo_lane
  import ofifo_pkg::*;
#(
  parameter int PSUM_BW = DEF_PSUM_BW,
  parameter int DEPTH   = DEF_DEPTH,
  localparam int PW     = ptr_w(DEPTH),
  localparam int CW     = cnt_w(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               wr,
  input  logic               pop,
  input  logic [PSUM_BW-1:0] din,
  output logic [PSUM_BW-1:0] rdata,
  output logic [CW-1:0]      count,
  output logic               empty,
  output logic               full
);

  logic [PSUM_BW-1:0] mem [DEPTH];
  logic [PW-1:0]      rptr;
  logic [PW-1:0]      wptr;
  logic               do_wr;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign do_wr = wr && !full;
  assign rdata = mem[rptr];

  // pop is only asserted by the top when every lane is non-empty.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (do_wr) wptr <= wptr + PW'(1);
      if (pop)   rptr <= rptr + PW'(1);
      count <= count + CW'(do_wr) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr && !reset && !flush) mem[wptr] <= din;
  end

endmodule

// File: rtl/ofifo_param.sv
// rtl/ofifo_param.sv - multi-lane output FIFO popped one full row at a time
module ofifo_param
  import ofifo_pkg::*;
#(
  parameter int COL       = DEF_COL,
  parameter int PSUM_BW   = DEF_PSUM_BW,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = DEPTH - DEF_AF_MARGIN,
  localparam int CW       = cnt_w(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [COL*PSUM_BW-1:0] in,
  input  logic [COL-1:0]         wr,
  input  logic                   rd,
  input  logic                   flush,
  output logic [COL*PSUM_BW-1:0] out,
  output logic                   out_valid,
  output logic                   o_valid,
  output logic                   o_ready,
  output logic                   o_full,
  output logic                   o_almost_full,
  output logic [CW-1:0]          o_rows,
  output logic [COL-1:0]         o_overflow,
  output logic                   o_underflow
);

  logic [CW-1:0]          cnt [COL];
  logic [COL-1:0]         empty;
  logic [COL-1:0]         full;
  logic [COL*PSUM_BW-1:0] rdata;
  logic                   pop;

  assign pop = rd && o_valid;

  for (genvar i = 0; i < COL; i++) begin : g_lane
    ofifo_lane #(
      .PSUM_BW(PSUM_BW),
      .DEPTH  (DEPTH)
    ) u_lane (
      .clk  (clk),
      .reset(reset),
      .flush(flush),
      .wr   (wr[i]),
      .pop  (pop),
      .din  (in[PSUM_BW*i +: PSUM_BW]),
      .rdata(rdata[PSUM_BW*i +: PSUM_BW]),
      .count(cnt[i]),
      .empty(empty[i]),
      .full (full[i])
    );
  end

  assign o_valid = ~|empty;
  assign o_full  = |full;
  assign o_ready = ~o_full;

  always_comb begin
    o_almost_full = 1'b0;
    o_rows        = cnt[0];
    for (int i = 0; i < COL; i++) begin
      if (cnt[i] >= CW'(AF_THRESH)) o_almost_full = 1'b1;
      if (cnt[i] < o_rows)          o_rows = cnt[i];
    end
  end

  // Overflow uses the pre-edge full flag, so a same-edge pop does not rescue the write.
  always_ff @(posedge clk) begin
    if (reset) begin
      out         <= '0;
      out_valid   <= 1'b0;
      o_overflow  <= '0;
      o_underflow <= 1'b0;
    end else if (flush) begin
      out_valid   <= 1'b0;
      o_overflow  <= '0;
      o_underflow <= 1'b0;
    end else begin
      out_valid  <= pop;
      if (pop) out <= rdata;
      o_overflow <= o_overflow | (wr & full);
      if (rd && !o_valid) o_underflow <= 1'b1;
    end
  end

endmodule

// File: doc/ofifo_param.md
OFIFO_PARAM -- requirements
Module: ofifo_param

Interface
REQ-001 Parameter COL, default 8: number of independent column lanes.
REQ-002 Parameter PSUM_BW, default 16: bits per lane entry.
REQ-003 Parameter DEPTH, default 64: entries per lane; power of two, >= 2.
REQ-004 Parameter AF_THRESH, default DEPTH-4: almost-full level; 1 <= AF_THRESH <= DEPTH.
REQ-005 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port in, input, COL*PSUM_BW: lane i data at bits [PSUM_BW*(i+1)-1 : PSUM_BW*i].
REQ-008 Port wr, input, COL: per-lane write strobe.
REQ-009 Port rd, input, 1: row-pop request across all lanes.
REQ-010 Port flush, input, 1: clears contents without a reset.
REQ-011 Port out, output, COL*PSUM_BW: popped row, same lane packing as in.
REQ-012 Port out_valid, output, 1: out holds a newly popped row this cycle.
REQ-013 Port o_valid, output, 1: every lane is non-empty, so a row is poppable.
REQ-014 Port o_ready, output, 1: no lane is full.
REQ-015 Port o_full, output, 1: at least one lane is full.
REQ-016 Port o_almost_full, output, 1: at least one lane count >= AF_THRESH.
REQ-017 Port o_rows, output, $clog2(DEPTH)+1: minimum count over all lanes, i.e. complete rows stored.
REQ-018 Port o_overflow, output, COL: sticky per-lane flag, set when a write is dropped.
REQ-019 Port o_underflow, output, 1: sticky flag, set when rd is ignored.

Function
REQ-020 Each lane shall be a circular buffer with read and write pointers of $clog2(DEPTH) bits, wrapping from DEPTH-1 to 0, and a count of 0..DEPTH.
REQ-021 A write to lane i shall occur at the edge where wr[i]=1 and lane i was not full before that edge.
REQ-022 A write to a full lane shall be dropped and shall set o_overflow[i]; this holds even if a pop occurs on the same edge.
REQ-023 A pop shall be accepted at the edge where rd=1 and o_valid=1, and shall advance the read pointer of every lane simultaneously.
REQ-024 Popped data shall appear on out after that edge (1-cycle latency), with out_valid=1 for exactly that cycle.
REQ-025 out shall hold its last value while no pop is accepted.
REQ-026 rd=1 while o_valid=0 shall be ignored, shall set o_underflow, and shall leave out_valid=0.
REQ-027 A simultaneous accepted write and pop on one lane shall leave that lane's count unchanged; data written to an empty lane shall not be poppable until the next cycle.
REQ-028 o_valid, o_ready, o_full, o_almost_full and o_rows shall be combinational from the lane counts (registered state only).
REQ-029 flush=1 shall take priority over rd and wr: at that edge all pointers, counts, o_overflow, o_underflow and out_valid go to 0, and out is unchanged.
REQ-030 Lanes shall operate independently; a non-uniform wr pattern leads to unequal counts, and o_rows reports the minimum.

Reset
REQ-031 reset=1 at an edge shall clear all pointers, counts and sticky flags, set out to 0 and out_valid to 0, and take priority over flush, rd and wr.
REQ-032 After reset the outputs shall be o_valid=0, o_ready=1, o_full=0, o_almost_full=0 and o_rows=0.
REQ-033 Reset asserted mid-stream shall discard all stored data; the first post-reset pop returns only data written after reset.

Structure
REQ-034 Default parameter values and the pointer/count width function shall live in the shared ofifo package/header, and the module shall use them.
REQ-035 One sub-module, ofifo_lane (a single-lane buffer exposing count, empty, full and the read word), shall be instantiated COL times by a generate loop; flag reduction and the output register shall sit in the top.

Verification
REQ-036 With COL=4, DEPTH=8 and AF_THRESH=6: reset, then write rows 0x0001..0x0008 to all lanes -> o_full=1, o_ready=0, o_rows=8, and o_almost_full=1 from the 6th write.
REQ-037 A 9th write of 0xDEAD to all lanes shall leave o_overflow=4'b1111, and eight pops shall return 0x0001..0x0008 in order, each with out_valid=1 one cycle after its pop.
REQ-038 Write lanes 0-2 only, three times -> o_valid=0 and o_rows=0; rd then sets o_underflow=1 and out_valid stays 0; one write to lane 3 -> o_valid=1.
REQ-039 Fill to count 5, then write and pop on the same edge for 20 cycles -> count stays 5, pointers wrap without error, and data order is preserved.
REQ-040 Fill with 3 rows, flush=1 together with rd=1 -> o_rows=0, out_valid=0, and out keeps its prior value.
REQ-041 Reset asserted at the same edge as wr and rd with 4 rows stored -> all counts are 0 and the next written row is the next row popped.
